// File: rtl/mux_nto1_scan_pkg.sv
// Shared types and constants for the N-to-1 registered scan multiplexer.
// Optional feature macro used across this slice: MUX_SCAN_MASK_EN.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } mux_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Bus bundle between the input bank driver and the scan multiplexer.
// The master drives the channel data and controls; the slave (the mux)
// returns the registered selection, its flags and the FSM state for checkers.
// With MUX_SCAN_MASK_EN defined, the bundle also carries the channel mask.
// Handshake: there is no backpressure. 'en' qualifies the inputs on each rising
// edge, and 'dout_valid' is high for exactly the cycle after an enabled edge
// that produced new data.
interface mux_nto1_scan_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    import mux_pkg::*;

    localparam int SELW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] din;
    logic [SELW-1:0]           sel;
    logic                      mode;
    logic                      en;
`ifdef MUX_SCAN_MASK_EN
    logic [CHANNELS-1:0]       ch_mask;
`endif
    logic [WIDTH-1:0]          dout;
    logic                      dout_valid;
    logic [SELW-1:0]           cur_ch;
    logic                      sel_err;
    mux_state_t                state;

`ifdef MUX_SCAN_MASK_EN
    modport master (
        output din, sel, mode, en, ch_mask,
        input  dout, dout_valid, cur_ch, sel_err, state
    );
    modport slave (
        input  din, sel, mode, en, ch_mask,
        output dout, dout_valid, cur_ch, sel_err, state
    );
`else
    modport master (
        output din, sel, mode, en,
        input  dout, dout_valid, cur_ch, sel_err, state
    );
    modport slave (
        input  din, sel, mode, en,
        output dout, dout_valid, cur_ch, sel_err, state
    );
`endif

endinterface

// File: rtl/mux_nto1_scan_ctrl.sv
// Scan sequencer: dwell counter, next-channel selection and wrap-around.
// i_start marks the enabled cycle that enters scan; that cycle presents the
// first channel with a fresh dwell count, so there is no dead cycle on entry.
// With MUX_SCAN_MASK_EN defined, only channels whose mask bit is set are
// visited; the mask is consulted only when choosing the next channel, so a
// channel masked off mid-dwell still finishes its dwell.
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SELW    = $clog2(CHANNELS),
    localparam int CNTW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_step,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0] i_mask,
`endif
    output logic [SELW-1:0]     o_ch,
    output logic                o_adv,
    output logic                o_none
);

    logic [SELW-1:0] r_ch;
    logic [CNTW-1:0] r_cnt;
    logic [SELW-1:0] w_first;
    logic [SELW-1:0] w_eff_ch;
    logic [CNTW-1:0] w_eff_cnt;
    logic [SELW-1:0] w_next_ch;
    logic            w_last;

    // Pick the entry channel and the channel following the one on show.
`ifdef MUX_SCAN_MASK_EN
    always_comb begin
        logic w_found;
        w_first   = '0;
        w_next_ch = w_eff_ch;
        w_found   = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i_mask[i]) w_first = SELW'(i);
        end
        for (int i = 1; i <= CHANNELS; i++) begin
            int idx;
            idx = (int'(w_eff_ch) + i) % CHANNELS;
            if (!w_found && i_mask[idx]) begin
                w_next_ch = SELW'(idx);
                w_found   = 1'b1;
            end
        end
        o_none = (i_mask == '0);
    end
`else
    always_comb begin
        w_first   = '0;
        w_next_ch = (w_eff_ch == SELW'(CHANNELS - 1)) ? '0 : w_eff_ch + SELW'(1);
        o_none    = 1'b0;
    end
`endif

    // Entry overrides the stored position so the first scan cycle is channel-first.
    always_comb begin
        w_eff_ch  = i_start ? w_first : r_ch;
        w_eff_cnt = i_start ? '0 : r_cnt;
        w_last    = (w_eff_cnt == CNTW'(DWELL - 1));
        o_ch      = w_eff_ch;
        o_adv     = i_step && !o_none && w_last;
    end

    // Advance the dwell counter and channel on each productive scan cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch  <= '0;
            r_cnt <= '0;
        end else if (i_step && !o_none) begin
            if (w_last) begin
                r_cnt <= '0;
                r_ch  <= w_next_ch;
            end else begin
                r_cnt <= w_eff_cnt + CNTW'(1);
                r_ch  <= w_eff_ch;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-to-1 registered multiplexer with manual select and round-robin scan.
// Optional channel mask in scan mode when MUX_SCAN_MASK_EN is defined.
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    mux_nto1_scan_if.slave bus
);

    localparam logic [SELW:0] CH_LIM = (SELW + 1)'(CHANNELS);

    mux_state_t       r_state;
    mux_state_t       w_next_state;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic [SELW-1:0]  r_cur_ch;
    logic             r_sel_err;
    logic             w_sel_ok;
    logic [WIDTH-1:0] w_man_data;
    logic [WIDTH-1:0] w_scan_data;
    logic [SELW-1:0]  w_scan_ch;
    logic             w_scan_adv;
    logic             w_scan_none;
    logic             w_scan_start;
    logic             w_scan_step;

    // Next-state: leave IDLE on the first enabled cycle, then follow mode.
    always_comb begin
        w_next_state = r_state;
        if (bus.en) begin
            w_next_state = (bus.mode == MODE_SCAN) ? SCAN : MANUAL;
        end
        w_scan_start = bus.en && (w_next_state == SCAN) && (r_state != SCAN);
        w_scan_step  = bus.en && (w_next_state == SCAN);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Slice the packed input bank for the manual and scan selections.
    always_comb begin
        w_sel_ok    = ({1'b0, bus.sel} < CH_LIM);
        w_man_data  = '0;
        w_scan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.sel == SELW'(k))   w_man_data  = bus.din[k*WIDTH +: WIDTH];
            if (w_scan_ch == SELW'(k)) w_scan_data = bus.din[k*WIDTH +: WIDTH];
        end
    end

    mux_scan_ctrl #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_scan_start),
        .i_step  (w_scan_step),
`ifdef MUX_SCAN_MASK_EN
        .i_mask  (bus.ch_mask),
`endif
        .o_ch    (w_scan_ch),
        .o_adv   (w_scan_adv),
        .o_none  (w_scan_none)
    );

    // Output registers: updated according to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_cur_ch  <= '0;
            r_sel_err <= 1'b0;
        end else if (!bus.en) begin
            r_valid <= 1'b0;
        end else begin
            case (w_next_state)
                MANUAL: begin
                    r_valid <= 1'b1;
                    if (w_sel_ok) begin
                        r_dout    <= w_man_data;
                        r_cur_ch  <= bus.sel;
                        r_sel_err <= 1'b0;
                    end else begin
                        r_dout    <= '0;
                        r_sel_err <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_scan_none) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_dout    <= w_scan_data;
                        r_cur_ch  <= w_scan_ch;
                        r_valid   <= 1'b1;
                        r_sel_err <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    // The advance strobe is informational here; sequencing lives in the ctrl.
    logic w_unused;
    assign w_unused = w_scan_adv;

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_valid;
    assign bus.cur_ch     = r_cur_ch;
    assign bus.sel_err    = r_sel_err;
    assign bus.state      = r_state;

endmodule
